// File: rtl/prco_fetch.sv
// -----------------------------------------------------------------------------
// prco_fetch -- instruction fetch unit for the PRCO core.
//
// Walks a word-addressed program counter, issues one instruction-memory read
// at a time, and hands each returned word to the decoder with a one-cycle
// q_ce strobe. A redirect (i_jump) either restarts the fetch at once or, when
// a read is already in flight, marks that read to be discarded on return.
//
// Optional feature (macro PRCO_FETCH_TIMEOUT_EN):
//   defined   -> a 4-bit watchdog counts WAIT cycles; 15 cycles without
//                i_mem_valid sets the sticky q_fault and parks the unit in
//                IDLE until reset.
//   undefined -> no watchdog, q_fault is constant 0, WAIT may last forever.
//
// Ports:
//   i_clk        in   1  clock, all state on posedge
//   i_reset      in   1  synchronous active-high reset
//   i_en         in   1  fetch enable, gates new requests from IDLE/HOLD
//   i_fetch      in   1  decoder pulse: fetch next instruction (HOLD only)
//   i_jump       in   1  redirect strobe
//   i_jump_addr  in  16  redirect target word address
//   q_mem_addr   out 16  instruction memory word address
//   q_mem_re     out  1  one-cycle read strobe per request
//   i_mem_data   in  16  read data, qualified by i_mem_valid
//   i_mem_valid  in   1  read data valid
//   q_instr      out 16  instruction word for the decoder
//   q_ce         out  1  one-cycle pulse: q_instr is new
//   q_pc         out 16  word address of the word in q_instr
//   q_fault      out  1  sticky fetch timeout flag
// -----------------------------------------------------------------------------
module prco_fetch (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_fetch,
  input  logic        i_jump,
  input  logic [15:0] i_jump_addr,
  output logic [15:0] q_mem_addr,
  output logic        q_mem_re,
  input  logic [15:0] i_mem_data,
  input  logic        i_mem_valid,
  output logic [15:0] q_instr,
  output logic        q_ce,
  output logic [15:0] q_pc,
  output logic        q_fault
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_HOLD  = 3'd4
  } state_t;

  state_t      state_r;
  logic [15:0] r_pc;    // address of the next word to request
  logic        r_drop;  // in-flight read belongs to a pre-jump address
  logic        fault_s; // unit is locked out by a fetch timeout

`ifdef PRCO_FETCH_TIMEOUT_EN
  logic [3:0]  tmo_cnt_r;
  logic        fault_r;

  assign fault_s = fault_r;
  assign q_fault = fault_r;
`else
  assign fault_s = 1'b0;
  assign q_fault = 1'b0;
`endif

  // Fetch FSM: state, program counter and all registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r    <= ST_IDLE;
      r_pc       <= 16'h0000;
      r_drop     <= 1'b0;
      q_pc       <= 16'h0000;
      q_instr    <= 16'h0000;
      q_ce       <= 1'b0;
      q_mem_re   <= 1'b0;
      q_mem_addr <= 16'h0000;
`ifdef PRCO_FETCH_TIMEOUT_EN
      tmo_cnt_r  <= 4'd0;
      fault_r    <= 1'b0;
`endif
    end else begin
      // Strobes are single-cycle unless a branch below re-asserts them.
      q_mem_re <= 1'b0;
      q_ce     <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (fault_s) begin
            state_r <= ST_IDLE;
          end else if (i_jump) begin
            r_pc       <= i_jump_addr;
            q_mem_addr <= i_jump_addr;
            q_mem_re   <= 1'b1;
            state_r    <= ST_REQ;
          end else if (i_en) begin
            q_mem_addr <= r_pc;
            q_mem_re   <= 1'b1;
            state_r    <= ST_REQ;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_REQ: begin
          // The read goes out this cycle regardless, so a jump here can only
          // mark its response for discard.
          if (i_jump) begin
            r_drop <= 1'b1;
            r_pc   <= i_jump_addr;
          end else begin
            r_drop <= r_drop;
          end
`ifdef PRCO_FETCH_TIMEOUT_EN
          tmo_cnt_r <= 4'd0;
`endif
          state_r <= ST_WAIT;
        end

        ST_WAIT: begin
          if (i_mem_valid) begin
            if (i_jump) begin
              // Response and redirect coincide: the read is complete, so the
              // data is discarded and the new target is requested directly.
              r_drop     <= 1'b0;
              r_pc       <= i_jump_addr;
              q_mem_addr <= i_jump_addr;
              q_mem_re   <= 1'b1;
              state_r    <= ST_REQ;
            end else if (r_drop) begin
              r_drop     <= 1'b0;
              q_mem_addr <= r_pc;
              q_mem_re   <= 1'b1;
              state_r    <= ST_REQ;
            end else begin
              q_instr <= i_mem_data;
              q_pc    <= r_pc;
              r_pc    <= r_pc + 16'd1;
              q_ce    <= 1'b1;
              state_r <= ST_ISSUE;
            end
          end else begin
            if (i_jump) begin
              r_drop <= 1'b1;
              r_pc   <= i_jump_addr;
            end else begin
              r_drop <= r_drop;
            end
`ifdef PRCO_FETCH_TIMEOUT_EN
            // Count 14 means this is the 15th silent WAIT cycle.
            tmo_cnt_r <= tmo_cnt_r + 4'd1;
            if (tmo_cnt_r == 4'd14) begin
              fault_r <= 1'b1;
              r_drop  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              fault_r <= fault_r;
            end
`endif
          end
        end

        ST_ISSUE: begin
          // q_ce was raised on entry and fires this cycle even on a jump.
          if (i_jump) begin
            r_pc       <= i_jump_addr;
            q_mem_addr <= i_jump_addr;
            q_mem_re   <= 1'b1;
            state_r    <= ST_REQ;
          end else begin
            state_r <= ST_HOLD;
          end
        end

        ST_HOLD: begin
          if (i_jump) begin
            r_pc       <= i_jump_addr;
            q_mem_addr <= i_jump_addr;
            q_mem_re   <= 1'b1;
            state_r    <= ST_REQ;
          end else if (i_fetch) begin
            if (i_en) begin
              q_mem_addr <= r_pc;
              q_mem_re   <= 1'b1;
              state_r    <= ST_REQ;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            state_r <= ST_HOLD;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prco_fetch.sv
// -----------------------------------------------------------------------------
// tb_prco_fetch -- self-checking bench for prco_fetch.
// Directed stimulus pushes expected requests and expected decoder words into
// queues; a negedge monitor pops and compares whenever q_mem_re or q_ce fires.
// A small memory responder answers requests with a programmable latency.
// -----------------------------------------------------------------------------
module tb_prco_fetch;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_en;
  logic        i_fetch;
  logic        i_jump;
  logic [15:0] i_jump_addr;
  logic [15:0] q_mem_addr;
  logic        q_mem_re;
  logic [15:0] i_mem_data;
  logic        i_mem_valid;
  logic [15:0] q_instr;
  logic        q_ce;
  logic [15:0] q_pc;
  logic        q_fault;

  always #5 i_clk = ~i_clk;

  prco_fetch dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_en        (i_en),
    .i_fetch     (i_fetch),
    .i_jump      (i_jump),
    .i_jump_addr (i_jump_addr),
    .q_mem_addr  (q_mem_addr),
    .q_mem_re    (q_mem_re),
    .i_mem_data  (i_mem_data),
    .i_mem_valid (i_mem_valid),
    .q_instr     (q_instr),
    .q_ce        (q_ce),
    .q_pc        (q_pc),
    .q_fault     (q_fault)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- memory responder ----------------
  logic [15:0] mem [logic [15:0]];
  int          lat  = 1;
  bit          mute = 1'b0;
  int          pend = 0;
  logic [15:0] pend_addr = 16'h0000;
  logic        auto_valid = 1'b0;
  logic        man_valid  = 1'b0;
  logic [15:0] auto_data  = 16'h0000;
  logic [15:0] man_data   = 16'h0000;

  assign i_mem_valid = auto_valid | man_valid;
  assign i_mem_data  = man_valid ? man_data : auto_data;

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  initial begin
    forever begin
      @(posedge i_clk);
      #1;
      auto_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          auto_valid = 1'b1;
          auto_data  = mem_rd(pend_addr);
        end
      end
      if (q_mem_re && !mute) begin
        pend_addr = q_mem_addr;
        pend      = lat;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [15:0] addr;
    int          ce_gap;   // cycles since last q_ce, -1 = unchecked
  } req_t;
  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
    int          gap;      // cycles since the producing q_mem_re
  } ce_t;

  req_t req_q[$];
  ce_t  ce_q[$];
  req_t mon_r;
  ce_t  mon_c;
  int   re_seen = 0;
  int   ce_seen = 0;
  int   last_re_cyc = 0;
  int   last_ce_cyc = 0;

  task automatic push_req(input logic [15:0] a, input int g);
    req_t r;
    r.addr = a; r.ce_gap = g;
    req_q.push_back(r);
  endtask

  task automatic push_ce(input logic [15:0] ins, input logic [15:0] pc, input int g);
    ce_t c;
    c.instr = ins; c.pc = pc; c.gap = g;
    ce_q.push_back(c);
  endtask

  initial begin
    forever begin
      @(negedge i_clk);
      if (q_mem_re) begin
        re_seen++;
        if (req_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_req: got addr %h expected no request", q_mem_addr);
        end else begin
          mon_r = req_q.pop_front();
          check16("req_addr", q_mem_addr, mon_r.addr);
          if (mon_r.ce_gap >= 0) checkint("fetch_to_req_gap", cyc - last_ce_cyc, mon_r.ce_gap);
        end
        last_re_cyc = cyc;
      end
      if (q_ce) begin
        ce_seen++;
        if (ce_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_ce: got instr %h pc %h expected no q_ce", q_instr, q_pc);
        end else begin
          mon_c = ce_q.pop_front();
          check16("ce_instr", q_instr, mon_c.instr);
          check16("ce_pc", q_pc, mon_c.pc);
          checkint("req_to_ce_gap", cyc - last_re_cyc, mon_c.gap);
        end
        last_ce_cyc = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ce(input int n);
    int t;
    t = 0;
    while (ce_seen < n && t < 100) begin
      @(posedge i_clk);
      t++;
    end
    checks++;
    if (ce_seen < n) begin
      fails++;
      $display("FAIL ce_timeout: got %0d pulses expected %0d", ce_seen, n);
    end
    #1;
  endtask

  task automatic fetch_pulse();
    i_fetch = 1'b1;
    tick(1);
    i_fetch = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge i_clk);
    check16({tag, "_mem_addr"}, q_mem_addr, 16'h0000);
    check16({tag, "_mem_re"},   {15'd0, q_mem_re}, 16'h0000);
    check16({tag, "_instr"},    q_instr, 16'h0000);
    check16({tag, "_ce"},       {15'd0, q_ce}, 16'h0000);
    check16({tag, "_pc"},       q_pc, 16'h0000);
    check16({tag, "_fault"},    {15'd0, q_fault}, 16'h0000);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base_re;
    i_reset = 1'b1; i_en = 1'b0; i_fetch = 1'b0; i_jump = 1'b0; i_jump_addr = 16'h0000;
    tick(3);
    i_reset = 1'b0;
    check_reset_outputs("rst");
    tick(3);   // enable low: no request may appear

    // Basic fetch, 1-cycle memory
    mem[16'h0000] = 16'h4A05;
    lat = 1;
    push_req(16'h0000, -1);
    push_ce(16'h4A05, 16'h0000, 2);
    i_en = 1'b1;
    wait_ce(1);
    tick(3);
    check16("hold_instr", q_instr, 16'h4A05);
    check16("hold_pc", q_pc, 16'h0000);

    // Three sequential fetches, 3-cycle memory, immediate i_fetch
    i_en = 1'b0; i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    mem[16'h0000] = 16'h1A00; mem[16'h0001] = 16'h1A01; mem[16'h0002] = 16'h1A02;
    lat = 3;
    push_req(16'h0000, -1); push_ce(16'h1A00, 16'h0000, 4);
    push_req(16'h0001, 2);  push_ce(16'h1A01, 16'h0001, 4);
    push_req(16'h0002, 2);  push_ce(16'h1A02, 16'h0002, 4);
    i_en = 1'b1;
    wait_ce(2);
    fetch_pulse();
    wait_ce(3);
    fetch_pulse();
    wait_ce(4);

    // Jump during WAIT: stale 0xDEAD is discarded
    mem[16'h0003] = 16'hDEAD; mem[16'h0100] = 16'h1234;
    push_req(16'h0003, 2);
    push_req(16'h0100, -1);
    push_ce(16'h1234, 16'h0100, 4);
    fetch_pulse();            // now in REQ
    tick(1);                  // now in WAIT
    i_jump = 1'b1; i_jump_addr = 16'h0100;
    tick(1);
    i_jump = 1'b0;
    wait_ce(5);
    check16("after_drop_instr", q_instr, 16'h1234);

    // PC wrap at 0xFFFF, then jump + fetch together in HOLD
    lat = 1;
    mem[16'hFFFF] = 16'hBEEF; mem[16'h0000] = 16'h0A0A; mem[16'h0200] = 16'h5A5A;
    push_req(16'hFFFF, -1); push_ce(16'hBEEF, 16'hFFFF, 2);
    i_jump = 1'b1; i_jump_addr = 16'hFFFF;
    tick(1);
    i_jump = 1'b0;
    wait_ce(6);
    push_req(16'h0000, 2); push_ce(16'h0A0A, 16'h0000, 2);
    fetch_pulse();
    wait_ce(7);
    push_req(16'h0200, 2); push_ce(16'h5A5A, 16'h0200, 2);
    i_jump = 1'b1; i_fetch = 1'b1; i_jump_addr = 16'h0200;
    tick(1);
    i_jump = 1'b0; i_fetch = 1'b0;
    wait_ce(8);

    // Reset in WAIT with a late response
    mute = 1'b1;
    push_req(16'h0201, 2);
    fetch_pulse();            // REQ
    tick(1);                  // WAIT
    i_reset = 1'b1; i_en = 1'b0;
    tick(1);
    i_reset = 1'b0;
    man_valid = 1'b1; man_data = 16'hDEAD;
    tick(1);
    man_valid = 1'b0;
    tick(3);
    check_reset_outputs("wait_rst");
    checkint("no_ce_after_reset", ce_seen, 8);

    // Memory never answers
    base_re = re_seen;
    push_req(16'h0000, -1);
    i_en = 1'b1;
    tick(24);
`ifdef PRCO_FETCH_TIMEOUT_EN
    @(negedge i_clk);
    check16("timeout_fault", {15'd0, q_fault}, 16'h0001);
    tick(10);
    checkint("no_req_after_fault", re_seen, base_re + 1);
    check16("fault_sticky", {15'd0, q_fault}, 16'h0001);
`else
    @(negedge i_clk);
    check16("no_timeout_fault", {15'd0, q_fault}, 16'h0000);
    tick(10);
    checkint("wait_forever_one_req", re_seen, base_re + 1);
    check16("no_timeout_fault_late", {15'd0, q_fault}, 16'h0000);
`endif

    checkint("req_queue_drained", req_q.size(), 0);
    checkint("ce_queue_drained", ce_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
